// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with an input FIFO. Baud divisor, parity mode and stop-bit
// count can be changed at runtime. A frame waiting in the FIFO follows the
// previous frame's last stop bit with no idle gap.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     push request; a push happens on an edge with in_valid && in_ready
//   in_data      frame payload, LSB sent first (hold until accepted)
//   in_ready     FIFO can accept (= !fifo_full)
//   cfg_div      bit period minus one, in clk cycles
//   cfg_parity   00 none, 01 even, 10 odd, 11 none
//   cfg_stop2    1 = two stop bits, 0 = one
//   tx           serial line, idle high, registered
//   busy         frame in progress or FIFO not empty (registered)
//   fifo_level   current FIFO entry count
//   fifo_empty   level == 0
//   fifo_full    level == FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          in_ready,
   input  logic [DIV_W-1:0]              cfg_div,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          fifo_empty,
   output logic                          fifo_full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Parity modes 01 and 10 add a parity bit; 00 and 11 do not.
   function automatic logic parity_en(input logic [1:0] mode);
      return (mode == 2'b01) || (mode == 2'b10);
   endfunction

   // Even parity is the XOR of the payload; odd parity is its inverse.
   function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic [1:0] mode);
      return (^d) ^ (mode == 2'b10);
   endfunction

   // FIFO
   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic [LVL_W-1:0]  level_nxt_s;
   logic              empty_r;
   logic              full_r;
   logic              push_s;
   logic              pop_s;

   // Transmitter
   state_t            state_r;
   logic [DIV_W-1:0]  cnt_r;
   logic [DIV_W-1:0]  div_r;
   logic              par_en_r;
   logic              par_bit_r;
   logic              stop2_r;
   logic              stop_cnt_r;
   logic [IDX_W-1:0]  idx_r;
   logic [DATA_W-1:0] shift_r;
   logic              tx_r;
   logic              busy_r;
   logic              tick_s;
   logic              last_stop_s;
   logic              start_s;
   logic              line_s;

   // Handshake, bit tick, frame-start opportunity and next FIFO level
   always_comb begin
      push_s      = in_valid && !full_r;
      tick_s      = (cnt_r == div_r);
      last_stop_s = tick_s && (!stop2_r || stop_cnt_r);
      case (state_r)
         ST_IDLE: start_s = 1'b1;
         ST_STOP: start_s = last_stop_s;
         default: start_s = 1'b0;
      endcase
      pop_s = start_s && !empty_r;
      if (push_s && !pop_s) begin
         level_nxt_s = level_r + LVL_W'(1);
      end else if (pop_s && !push_s) begin
         level_nxt_s = level_r - LVL_W'(1);
      end else begin
         level_nxt_s = level_r;
      end
   end

   // Line value for the current state; tx registers it one cycle later
   always_comb begin
      case (state_r)
         ST_IDLE:   line_s = 1'b1;
         ST_START:  line_s = 1'b0;
         ST_DATA:   line_s = shift_r[0];
         ST_PARITY: line_s = par_bit_r;
         ST_STOP:   line_s = 1'b1;
         default:   line_s = 1'b1;
      endcase
   end

   // FIFO storage, pointers and occupancy flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         level_r <= level_nxt_s;
         empty_r <= (level_nxt_s == {LVL_W{1'b0}});
         full_r  <= (level_nxt_s == LVL_W'(FIFO_DEPTH));
      end
   end

   // Frame FSM: bit timing, shifter, latched config and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {DIV_W{1'b0}};
         div_r      <= {DIV_W{1'b0}};
         par_en_r   <= 1'b0;
         par_bit_r  <= 1'b0;
         stop2_r    <= 1'b0;
         stop_cnt_r <= 1'b0;
         idx_r      <= {IDX_W{1'b0}};
         shift_r    <= {DATA_W{1'b0}};
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         tx_r   <= line_s;
         busy_r <= (state_r != ST_IDLE) || !empty_r;
         if (pop_s) begin
            // Config is captured here so mid-frame changes only affect later frames.
            state_r    <= ST_START;
            cnt_r      <= {DIV_W{1'b0}};
            div_r      <= cfg_div;
            par_en_r   <= parity_en(cfg_parity);
            par_bit_r  <= parity_bit(mem_r[rd_ptr_r], cfg_parity);
            stop2_r    <= cfg_stop2;
            stop_cnt_r <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            shift_r    <= mem_r[rd_ptr_r];
         end else begin
            case (state_r)
               ST_IDLE: begin
                  cnt_r <= {DIV_W{1'b0}};
               end
               ST_START: begin
                  if (tick_s) begin
                     cnt_r   <= {DIV_W{1'b0}};
                     idx_r   <= {IDX_W{1'b0}};
                     state_r <= ST_DATA;
                  end else begin
                     cnt_r <= cnt_r + DIV_W'(1);
                  end
               end
               ST_DATA: begin
                  if (tick_s) begin
                     cnt_r   <= {DIV_W{1'b0}};
                     shift_r <= {1'b0, shift_r[DATA_W-1:1]};
                     if (idx_r == IDX_W'(DATA_W - 1)) begin
                        stop_cnt_r <= 1'b0;
                        state_r    <= par_en_r ? ST_PARITY : ST_STOP;
                     end else begin
                        idx_r <= idx_r + IDX_W'(1);
                     end
                  end else begin
                     cnt_r <= cnt_r + DIV_W'(1);
                  end
               end
               ST_PARITY: begin
                  if (tick_s) begin
                     cnt_r      <= {DIV_W{1'b0}};
                     stop_cnt_r <= 1'b0;
                     state_r    <= ST_STOP;
                  end else begin
                     cnt_r <= cnt_r + DIV_W'(1);
                  end
               end
               ST_STOP: begin
                  if (tick_s) begin
                     cnt_r <= {DIV_W{1'b0}};
                     // A back-to-back pop on the last tick is handled by the pop branch.
                     if (last_stop_s) begin
                        state_r <= ST_IDLE;
                     end else begin
                        stop_cnt_r <= 1'b1;
                     end
                  end else begin
                     cnt_r <= cnt_r + DIV_W'(1);
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  cnt_r   <= {DIV_W{1'b0}};
               end
            endcase
         end
      end
   end

   assign in_ready   = !full_r;
   assign tx         = tx_r;
   assign busy       = busy_r;
   assign fifo_level = level_r;
   assign fifo_empty = empty_r;
   assign fifo_full  = full_r;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised 8N1-successor UART transmitter with a runtime-configurable baud divisor, parity mode and stop-bit count.
- Includes an input FIFO with a valid/ready push interface.
- Sits between the SoC peripheral bus register block and the tx pad.
- Replaces the fixed-format single-byte transmitter and allows back-to-back frames with no idle gap.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  push request
- in_data  in  DATA_W  frame payload, LSB sent first
- in_ready  out  1  FIFO can accept; equals !fifo_full
- cfg_div  in  DIV_W  bit period minus 1, in clk cycles
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
- cfg_stop2  in  1  1 = two stop bits, 0 = one
- tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress or FIFO not empty
- fifo_level  out  clog2(FIFO_DEPTH)+1  current entry count
- fifo_empty  out  1  level == 0
- fifo_full  out  1  level == FIFO_DEPTH

Behaviour:
- Clock and reset: clk is the clock. rst_n is an asynchronous active-low reset.
- Reset values: tx=1, busy=0, fifo_level=0, fifo_empty=1, fifo_full=0, in_ready=1, state=IDLE, all counters 0.
- Reset mid-frame: tx returns to 1 immediately, the frame is abandoned and FIFO contents are discarded.
- Push: occurs on a clock edge where in_valid && in_ready. in_valid while full is ignored (no overwrite). in_data must hold until accepted.
- Pop: occurs in a cycle where the FSM starts a frame and the FIFO is non-empty. Push and pop in the same cycle leave the level unchanged. Pushing into an empty FIFO makes the data poppable on the next cycle; there is no bypass.
- Config sampling: cfg_div, cfg_parity and cfg_stop2 are latched at pop. Changes during a frame affect only later frames.
- Bit period: latched cfg_div+1 clk cycles. cfg_div=0 gives 1 cycle per bit. A bit counter counts 0..div and wraps; tick is asserted at count == div.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is not empty, pop, load the shifter, and go to START on the next edge, so tx falls one cycle after the pop.
  - START: tx=0 for one bit period.
  - DATA: DATA_W bits, LSB first, one bit period each. After the last bit, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: tx = XOR of the DATA_W payload bits for even parity, or its inverse for odd parity. Lasts one bit period.
  - STOP: tx=1 for 1 or 2 bit periods. On the final tick, if the FIFO is non-empty, pop and go directly to START (zero idle cycles between frames); otherwise go to IDLE.
- Frame length: (1 + DATA_W + P + S) × (div+1) cycles, where P is 0 or 1 and S is 1 or 2.
- busy: registered; equals (state != IDLE) || !fifo_empty.
- FIFO pointers: wrap modulo FIFO_DEPTH. Full and empty are distinguished by the level counter.
- Illegal state encodings recover to IDLE with tx=1.

Test Plan:
- DATA_W=8, cfg_div=3, parity none, 1 stop; push 0xA5 from idle -> tx falls 2 cycles after the accepted push. Each bit lasts 4 cycles. Sequence is 0,1,0,1,0,0,1,0,1,1 (40 cycles), then busy=0 one cycle later.
- Even parity, push 0x07 -> parity bit 1. Odd parity, push 0x07 -> parity bit 0. Both frames are 11 bits, 44 cycles at div=3.
- cfg_stop2=1, cfg_div=0, push 0x00 and 0xFF back-to-back -> frames are 11 cycles each. The second start bit immediately follows the second stop bit with no idle high cycle.
- FIFO_DEPTH=4, cfg_div=1000, in_valid held high with data 1,2,3,4,5,6 -> 5 bytes accepted (first is popped into the shifter). Then in_ready=0, fifo_full=1, fifo_level=4. The line later carries bytes 1..5 in order.
- During a frame at div=3, change cfg_div to 7 and cfg_parity to 01 -> the current frame is unchanged. The next frame uses 8-cycle bits and includes parity.
- Assert rst_n=0 during data bit 3 -> tx=1, busy=0 and fifo_level=0 immediately. After release, with no further pushes, the line stays idle.
